// File: rtl/bs_arb_pkg.sv
// Shared types and helpers for the bs_arbtr_rr_bp shared-bus arbiter.
package bs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int MAX_PKT_W = 128;

    // Destination ID is the top idw bits of a pkt_w-bit packet, zero-extended.
    function automatic logic [31:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                             input int pkt_w, input int idw);
        logic [31:0] d;
        d = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < idw) d[b] = pkt[pkt_w - idw + b];
        end
        return d;
    endfunction

endpackage

// File: rtl/bs_rr_picker.sv
// Combinational grant picker: round-robin after ptr, or fixed lowest-index priority.
module bs_rr_picker #(
    parameter int n  = 16,
    parameter int iw = 4
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    input  logic          fixed,
    output logic [n-1:0]  gnt,
    output logic [iw-1:0] idx,
    output logic          any
);

    int          j;
    logic [iw-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        // Fixed mode scans 0..n-1; round-robin scans ptr+1.. wrapping to ptr.
        for (int k = 1; k <= n; k++) begin
            if (fixed) j = k - 1;
            else       j = (int'(ptr) + k) % n;
            jj = iw'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                idx     = jj;
                gnt[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bs_arbtr_rr_bp.sv
// Shared-bus arbiter with RR/fixed arbitration, per-destination backpressure and broadcast.
// Optional statistics (drop_cnt, pkt_cnt) are built when BS_ARB_STATS_EN is defined.
module bs_arbtr_rr_bp
    import bs_arb_pkg::*;
#(
    parameter int               pckg_sz   = 32,
    parameter int               drvrs     = 16,
    parameter int               id_w      = 8,
    parameter logic [id_w-1:0]  broadcast = {id_w{1'b1}},
    parameter int               arb_mode  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    // Valid/ready: pop is the dequeue strobe against pndng; push fires only when no target is full.
    state_e             state, state_nxt;
    logic [IW-1:0]      g_q, ptr_q, pick_idx;
    logic [drvrs-1:0]   gnt_q, pick_gnt, mask_q, mask_nxt;
    logic               pick_any, invalid_q, invalid_nxt, deliver_ok;
    logic [pckg_sz-1:0] word_q, last_q, head;
    logic [MAX_PKT_W-1:0] head_ext;
    logic [31:0]        dest;

    bs_rr_picker #(.n(drvrs), .iw(IW)) u_picker (
        .req   (pndng),
        .ptr   (ptr_q),
        .fixed (arb_mode == ARB_FIXED),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        head        = D_pop[g_q*pckg_sz +: pckg_sz];
        head_ext    = '0;
        head_ext[pckg_sz-1:0] = head;
        dest        = get_dest(head_ext, pckg_sz, id_w);
        mask_nxt    = '0;
        invalid_nxt = 1'b0;
        if (dest == 32'(broadcast))   mask_nxt = ~(ONE << g_q);
        else if (dest < 32'(drvrs))   mask_nxt = ONE << dest;
        else                          invalid_nxt = 1'b1;
    end

    assign deliver_ok = (state == DELIVER) && !invalid_q && ((mask_q & full) == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = GRANT;
            GRANT:   state_nxt = DELIVER;
            DELIVER: if (invalid_q || deliver_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        pop    = (state == GRANT) ? gnt_q : '0;
        push   = deliver_ok ? mask_q : '0;
        D_push = deliver_ok ? word_q : last_q;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            g_q       <= '0;
            gnt_q     <= '0;
            ptr_q     <= IW'(drvrs - 1);
            word_q    <= '0;
            last_q    <= '0;
            mask_q    <= '0;
            invalid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                g_q   <= pick_idx;
                gnt_q <= pick_gnt;
            end
            if (state == GRANT) begin
                word_q    <= head;
                mask_q    <= mask_nxt;
                invalid_q <= invalid_nxt;
                if (arb_mode == ARB_RR) ptr_q <= g_q;
            end
            if (deliver_ok) last_q <= word_q;
        end
    end

`ifdef BS_ARB_STATS_EN
    logic [15:0] drop_q;
    logic [31:0] pkt_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (state == DELIVER && invalid_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (deliver_ok) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_bs_arbtr_rr_bp.sv
// Directed bench for bs_arbtr_rr_bp (drvrs=4): an RR instance and a fixed-priority instance.
module tb_bs_arbtr_rr_bp;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk, reset;
    logic [N-1:0]   pndng, full;
    logic [N*W-1:0] d_pop;
    logic [N-1:0]   pop, push, pop_f, push_f;
    logic [W-1:0]   d_push, d_push_f;
    logic           busy, busy_f;
    logic [15:0]    drop_cnt, drop_f;
    logic [15:0]    exp_drop;
    logic [N-1:0]   exp_gnt;
    logic [W-1:0]   e;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    bs_arbtr_rr_bp #(.pckg_sz(W), .drvrs(N), .id_w(8), .arb_mode(0)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
        .full(full), .push(push), .D_push(d_push), .busy(busy), .drop_cnt(drop_cnt)
    );

    bs_arbtr_rr_bp #(.pckg_sz(W), .drvrs(N), .id_w(8), .arb_mode(1)) dut_fp (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_f),
        .full(full), .push(push_f), .D_push(d_push_f), .busy(busy_f), .drop_cnt(drop_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        d_pop[i*W +: W] = w;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
`ifdef BS_ARB_STATS_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        reset = 1'b0;
        pndng = '0;
        full  = '0;
        d_pop = '0;

        step();
        check("rst_pop", pop, 4'b0000);
        check("rst_push", push, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_cnt, 16'd0);
        check("rst_dpush", d_push, 32'h0);
        reset = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // Unicast from agent 1 to agent 3
        set_word(1, 32'h0300_00AA);
        pndng = 4'b0010;
        step();
        check("uni_pop", pop, 4'b0010);
        check("uni_busy", busy, 1'b1);
        pndng = '0;
        step();
        check("uni_push", push, 4'b1000);
        check("uni_dpush", d_push, 32'h0300_00AA);
        step();
        check("uni_idle", busy, 1'b0);
        check("uni_push_off", push, 4'b0000);
        check("uni_dpush_hold", d_push, 32'h0300_00AA);

        // Broadcast from agent 2
        set_word(2, 32'hFF00_1234);
        pndng = 4'b0100;
        step();
        check("bc_pop", pop, 4'b0100);
        pndng = '0;
        step();
        check("bc_push", push, 4'b1011);
        check("bc_dpush", d_push, 32'hFF00_1234);
        step();
        check("bc_push_off", push, 4'b0000);
        check("bc_idle", busy, 1'b0);

        // Backpressure: agent 0 to agent 3 while full[3] is high for 5 cycles
        set_word(0, 32'h0300_0055);
        full  = 4'b1000;
        pndng = 4'b0001;
        step();
        check("bp_pop", pop, 4'b0001);
        pndng = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_wait_push", push, 4'b0000);
            check("bp_wait_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1 full = '0;
        step();
        check("bp_push", push, 4'b1000);
        check("bp_dpush", d_push, 32'h0300_0055);
        step();
        check("bp_idle", busy, 1'b0);

        // Invalid destination 8'h07 is popped and dropped
        set_word(1, 32'h0700_0000);
        pndng = 4'b0010;
        step();
        check("inv_pop", pop, 4'b0010);
        pndng = '0;
        step();
        check("inv_push", push, 4'b0000);
        check("inv_busy", busy, 1'b1);
        step();
        check("inv_idle", busy, 1'b0);
        check("inv_drop", drop_cnt, exp_drop);

        // Asynchronous reset while DELIVER waits on full
        set_word(2, 32'h0300_0077);
        full  = 4'b1000;
        pndng = 4'b0100;
        step();
        check("rmd_pop", pop, 4'b0100);
        pndng = '0;
        step();
        check("rmd_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rmd_pop0", pop, 4'b0000);
        check("rmd_push0", push, 4'b0000);
        check("rmd_busy0", busy, 1'b0);
        check("rmd_drop0", drop_cnt, 16'd0);
        check("rmd_dpush0", d_push, 32'h0);
        check("rmd_busy0_fp", busy_f, 1'b0);
        step();
        full = '0;
        for (int i = 0; i < N; i++) set_word(i, 32'h0000_00A0 + 32'(i));
        pndng = 4'b1111;
        reset = 1'b1;

        // Fairness: RR rotates 0,1,2,3,... starting at agent 0; fixed always grants 0
        for (int p = 0; p < 12; p++) exp_q.push_back(32'(p % N));
        for (int p = 0; p < 12; p++) begin
            step();
            e = exp_q.pop_front();
            exp_gnt = 4'b0001 << e;
            check("rr_pop", pop, exp_gnt);
            check("fp_pop", pop_f, 4'b0001);
            step();
            check("rr_push", push, 4'b0001);
            check("rr_dpush", d_push, 32'h0000_00A0 + e);
            check("fp_dpush", d_push_f, 32'h0000_00A0);
            step();
        end
        pndng = '0;
        step();
        step();
        check("end_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bs_arbtr_rr_bp.md
Name: bs_arbtr_rr_bp

Overview:
- Parametrised successor to the single-bus generator/arbiter: one shared bus serving `drvrs` agents.
- Adds selectable arbitration mode (round-robin or fixed priority), per-destination backpressure via `full`, explicit broadcast fan-out excluding the source, and invalid-destination drop.
- Sits between the agents' outbound FIFOs (`pndng`/`pop`/`D_pop`) and their inbound FIFOs (`push`/`D_push`).

Parameters:
- pckg_sz, 32, packet width in bits; destination ID in bits [pckg_sz-1 -: id_w].
- drvrs, 16, number of agents (2..64).
- id_w, 8, destination ID field width; must satisfy 2**id_w > drvrs.
- broadcast, {id_w{1'b1}}, ID value meaning "all agents except source".
- arb_mode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pndng  input  drvrs  agent i outbound FIFO non-empty.
- D_pop  input  drvrs*pckg_sz  head word of each agent's FIFO (first-word-fall-through); slice i at [i*pckg_sz +: pckg_sz].
- pop  output  drvrs  one-hot, one-cycle dequeue strobe.
- full  input  drvrs  agent i inbound FIFO cannot accept.
- push  output  drvrs  enqueue strobe per destination; multi-hot on broadcast.
- D_push  output  pckg_sz  bus word, shared by all destinations.
- busy  output  1  high in any state other than IDLE.
- drop_cnt  output  16  count of dropped packets.

Behaviour:
- Reset (async, reset=0):
  - pop, push, D_push, busy and drop_cnt all go to 0 immediately; state goes to IDLE.
  - RR pointer goes to drvrs-1, so agent 0 wins first.
  - A packet in flight is lost; its pop has already occurred.
- FSM IDLE -> GRANT -> DELIVER -> IDLE.
- IDLE:
  - If |pndng: register winner g, go to GRANT.
  - Round-robin: first set pndng index after the pointer, wrapping modulo drvrs.
  - Fixed priority: lowest set index.
- GRANT:
  - pop[g]=1 for exactly this cycle.
  - D_pop slice g is captured into the bus register.
  - Compute target mask:
    - dest==broadcast: all ones except bit g.
    - dest<drvrs: one-hot dest.
    - otherwise: invalid.
  - Go to DELIVER.
  - RR pointer updates to g here, round-robin mode only.
- DELIVER:
  - Invalid dest: no push, drop_cnt increments (saturating at 16'hFFFF), back to IDLE.
  - Else wait while (mask & full) != 0. push stays 0 while waiting; no timeout.
  - When the mask is clear: push=mask for one cycle with D_push = captured word, then IDLE.
  - Broadcast is all-or-nothing: no partial delivery.
  - Self-addressed unicast (dest==g) is legal and delivered to g.
- D_push holds its last value outside push cycles.
- Latency: pndng sampled high in cycle 0 -> pop in cycle 1 -> push earliest in cycle 2. Peak throughput is one packet per 3 cycles.
- pndng deasserting after the grant has no effect. A pndng change during DELIVER is ignored until IDLE.
- drvrs=2 broadcast targets exactly the other agent.

Optional Feature:
- Macro: BS_ARB_STATS_EN.
- Defined:
  - drop_cnt counts as described.
  - Internal 32-bit delivered-packet counter, incremented on each push cycle (broadcast counts once), observable hierarchically as pkt_cnt.
- Undefined:
  - drop_cnt tied to 0; no counters synthesised.
  - Invalid packets are still dropped silently.

Decomposition:
- Package bs_arb_pkg:
  - state enum (IDLE, GRANT, DELIVER).
  - arb_mode constants ARB_RR=0, ARB_FIXED=1.
  - function extracting dest ID from a packet.
- One sub-module, bs_rr_picker: combinational request vector + pointer + mode -> one-hot grant and index, reused by testbench models.

Test Plan:
- Unicast: drvrs=4, pndng=4'b0010, D_pop[1]=32'h0300_00AA, full=0 -> pop=4'b0010 at cycle 1; push=4'b1000, D_push=32'h0300_00AA at cycle 2; busy low at cycle 3.
- Round-robin fairness: all four pndng held high for 12 packets -> grant order 0,1,2,3,0,1,2,3,...; arb_mode=1 instead -> all 12 grants to agent 0.
- Broadcast: agent 2 sends 32'hFF00_1234 -> push=4'b1011 in a single cycle, D_push=32'hFF00_1234.
- Backpressure: unicast to agent 3 with full[3]=1 for 5 cycles -> push stays 0, busy stays 1; push=4'b1000 on the cycle after full[3] drops.
- Invalid destination: dest 8'h07 with drvrs=4 -> pop occurs, no push, drop_cnt 0->1 with BS_ARB_STATS_EN defined, stays 0 without it.
- Reset mid-DELIVER: drive reset low while waiting on full -> push, pop, busy and drop_cnt go to 0 asynchronously; after release, agent 0 wins first.
